// File: rtl/logic_op_serializer_if.sv
// Command/result bundle between a command source and the bit-serial logic controller.
// The master drives commands and accepts results; the slave is the controller.
interface logic_op_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_op;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_op, out_err
  );
endinterface

// File: rtl/logic_op_serializer.sv
// Bit-serial controller: runs a 1-bit logic gate cell over WIDTH-bit operands, LSB first,
// and assembles the result in place before offering it on a valid/ready output.
module logic_op_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_op_serializer_if.slave bus,
  output logic                 busy
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] result_reg;
  logic             err_reg;
  logic             valid_reg;

  logic a_bit;
  logic b_bit;
  logic gate_bit;

  // Single-bit gate cell fed from the current bit position.
  always_comb begin
    a_bit    = a_reg[cnt];
    b_bit    = b_reg[cnt];
    gate_bit = 1'b0;
    case (op_reg)
      OP_AND:  gate_bit = a_bit & b_bit;
      OP_OR:   gate_bit = a_bit | b_bit;
      OP_XOR:  gate_bit = a_bit ^ b_bit;
      OP_NOT:  gate_bit = ~a_bit;
      OP_NOR:  gate_bit = ~(a_bit | b_bit);
      OP_XNOR: gate_bit = ~(a_bit ^ b_bit);
      OP_NAND: gate_bit = ~(a_bit & b_bit);
      default: gate_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg      <= bus.in_a;
            b_reg      <= bus.in_b;
            op_reg     <= bus.in_op;
            cnt        <= '0;
            result_reg <= '0;
            if (bus.in_op == OP_ILL) begin
              state   <= DONE;
              err_reg <= 1'b1;
            end else begin
              state   <= RUN;
              err_reg <= 1'b0;
            end
          end
        end
        RUN: begin
          result_reg[cnt] <= gate_bit;
          if (cnt == LAST_BIT) begin
            state     <= DONE;
            valid_reg <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // An illegal op enters DONE straight from IDLE; valid rises one edge later.
          if (!valid_reg) begin
            valid_reg <= 1'b1;
          end else if (bus.out_ready) begin
            valid_reg <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = valid_reg;
  assign bus.out_result = result_reg;
  assign bus.out_op     = op_reg;
  assign bus.out_err    = err_reg;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_logic_op_serializer.sv
// Directed bench for logic_op_serializer: reset, every opcode, illegal op,
// output backpressure, asynchronous reset mid-run and operand stability.
module tb_logic_op_serializer;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic_op_serializer_if #(.WIDTH(WIDTH)) bus ();

  logic_op_serializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge with the DUT idle; returns #1 after the accept edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen; 40 means timed out.
  task automatic wait_out_valid(output int cycles);
    cycles = 0;
    while (cycles < 40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) break;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.out_result !== 8'h00) begin n_fail++; $display("FAIL reset_out_result: got %h expected 00", bus.out_result); end
    n_checks++;
    if (bus.out_op !== 3'd0) begin n_fail++; $display("FAIL reset_out_op: got %0d expected 0", bus.out_op); end
    n_checks++;
    if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", bus.out_err); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    $display("txn reset released in_ready=%b busy=%b", bus.in_ready, busy);
  endtask

  task automatic test_first_and();
    int cyc;
    bus.out_ready = 1'b1;
    send(3'd0, 8'hF0, 8'hCC);
    wait_out_valid(cyc);
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL and_latency: got %0d expected 8", cyc); end
    n_checks++;
    if (bus.out_result !== 8'hC0) begin n_fail++; $display("FAIL and_result: got %h expected c0", bus.out_result); end
    n_checks++;
    if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL and_err: got %b expected 0", bus.out_err); end
    $display("txn op=0 a=f0 b=cc result=%h err=%b latency=%0d", bus.out_result, bus.out_err, cyc);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL and_handoff: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_all_ops();
    logic [2:0] ops [6];
    logic [7:0] exp_res [6];
    int cyc;
    ops     = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    exp_res = '{8'hFC, 8'h3C, 8'h0F, 8'h03, 8'hC3, 8'h3F};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(ops[i], 8'hF0, 8'hCC);
      wait_out_valid(cyc);
      n_checks++;
      if (cyc !== 8) begin n_fail++; $display("FAIL op%0d_latency: got %0d expected 8", ops[i], cyc); end
      n_checks++;
      if (bus.out_result !== exp_res[i]) begin
        n_fail++; $display("FAIL op%0d_result: got %h expected %h", ops[i], bus.out_result, exp_res[i]);
      end
      n_checks++;
      if (bus.out_op !== ops[i]) begin n_fail++; $display("FAIL op%0d_out_op: got %0d expected %0d", ops[i], bus.out_op, ops[i]); end
      $display("txn op=%0d a=f0 b=cc result=%h err=%b", bus.out_op, bus.out_result, bus.out_err);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL op%0d_handoff: got valid=%b ready=%b expected valid=0 ready=1", ops[i], bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_illegal();
    int cyc;
    bus.out_ready = 1'b1;
    send(3'd7, 8'hFF, 8'hFF);
    wait_out_valid(cyc);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL ill_latency: got %0d expected 1", cyc); end
    n_checks++;
    if (bus.out_result !== 8'h00) begin n_fail++; $display("FAIL ill_result: got %h expected 00", bus.out_result); end
    n_checks++;
    if (bus.out_err !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b expected 1", bus.out_err); end
    n_checks++;
    if (bus.out_op !== 3'd7) begin n_fail++; $display("FAIL ill_out_op: got %0d expected 7", bus.out_op); end
    $display("txn op=7 a=ff b=ff result=%h err=%b latency=%0d", bus.out_result, bus.out_err, cyc);
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_handoff: got ready=%b expected 1", bus.in_ready); end
    send(3'd0, 8'h0F, 8'hFF);
    wait_out_valid(cyc);
    n_checks++;
    if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL ill_err_clear: got %b expected 0", bus.out_err); end
    n_checks++;
    if (bus.out_result !== 8'h0F) begin n_fail++; $display("FAIL ill_next_result: got %h expected 0f", bus.out_result); end
    $display("txn op=0 a=0f b=ff result=%h err=%b", bus.out_result, bus.out_err);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int cyc;
    bus.out_ready = 1'b0;
    send(3'd2, 8'hAA, 8'h55);
    wait_out_valid(cyc);
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL bp_latency: got %0d expected 8", cyc); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 8'hFF || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b result=%h ready=%b expected valid=1 result=ff ready=0",
                 i, bus.out_valid, bus.out_result, bus.in_ready);
      end
      if (i == 1) begin
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd1;
        bus.in_a     = 8'h0F;
        bus.in_b     = 8'hF0;
      end
    end
    $display("txn op=2 a=aa b=55 result=%h held 5 cycles", bus.out_result);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_pending_not_taken: got valid=%b ready=%b busy=%b expected valid=0 ready=1 busy=0",
               bus.out_valid, bus.in_ready, busy);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_out_valid(cyc);
    n_checks++;
    if (cyc !== 8 || bus.out_result !== 8'hFF || bus.out_op !== 3'd1) begin
      n_fail++;
      $display("FAIL bp_pending_result: got lat=%0d result=%h op=%0d expected lat=8 result=ff op=1",
               cyc, bus.out_result, bus.out_op);
    end
    $display("txn op=1 a=0f b=f0 result=%h", bus.out_result);
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int  cyc;
    logic seen_valid;
    bus.out_ready = 1'b1;
    send(3'd0, 8'hFF, 8'hFF);
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || bus.out_result !== 8'h07) begin
      n_fail++; $display("FAIL rst_mid_progress: got busy=%b result=%h expected busy=1 result=07", busy, bus.out_result);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_result !== 8'h00 ||
        bus.out_op !== 3'd0 || bus.out_err !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got busy=%b valid=%b result=%h op=%0d err=%b ready=%b expected 0 0 00 0 0 1",
               busy, bus.out_valid, bus.out_result, bus.out_op, bus.out_err, bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_valid: got out_valid after release expected none"); end
    $display("txn aborted op=0 by reset, out_valid seen=%b", seen_valid);
    send(3'd1, 8'h01, 8'h80);
    wait_out_valid(cyc);
    n_checks++;
    if (cyc !== 8 || bus.out_result !== 8'h81) begin
      n_fail++; $display("FAIL rst_mid_next: got lat=%0d result=%h expected lat=8 result=81", cyc, bus.out_result);
    end
    $display("txn op=1 a=01 b=80 result=%h", bus.out_result);
    @(negedge clk);
  endtask

  task automatic test_operand_change();
    int cyc;
    bus.out_ready = 1'b1;
    send(3'd0, 8'hFF, 8'h0F);
    bus.in_a  = 8'h00;
    bus.in_b  = 8'h00;
    bus.in_op = 3'd3;
    wait_out_valid(cyc);
    n_checks++;
    if (bus.out_result !== 8'h0F) begin n_fail++; $display("FAIL opchg_result: got %h expected 0f", bus.out_result); end
    n_checks++;
    if (bus.out_op !== 3'd0) begin n_fail++; $display("FAIL opchg_out_op: got %0d expected 0", bus.out_op); end
    $display("txn op=0 a=ff b=0f (changed later) result=%h", bus.out_result);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL opchg_handoff: got valid=%b expected 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_first_and();
    test_all_ops();
    test_illegal();
    test_backpressure();
    test_reset_mid_op();
    test_operand_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
